// File: rtl/result_readout_pkg.sv
// Shared types and elaboration helpers for the byte-serial result readout path.
package result_readout_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StRelease} state_e;

  function automatic int unsigned calc_lanes(input int unsigned data_w,
                                             input int unsigned out_w);
    return data_w / out_w;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

  // Maps a transmit-order index onto the physical lane of the snapshot.
  function automatic int unsigned lane_sel(input int unsigned idx,
                                           input int unsigned lanes,
                                           input bit          lsb_first);
    return lsb_first ? idx : (lanes - 1 - idx);
  endfunction

endpackage

// File: rtl/result_readout_sync_2ff.sv
// Two-flop synchronizer for pin-level inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/result_readout.sv
// Snapshots a core result and streams it out one beat at a time over a 4-phase valid/ack
// handshake with an external host.
module result_readout
  import result_readout_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned OUTWIDTH  = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned LANES    = calc_lanes(DATAWIDTH, OUTWIDTH),
  localparam int unsigned IDX_W    = calc_idx_w(LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 ack,
  output logic [OUTWIDTH-1:0]  byte_out,
  output logic                 byte_valid,
  output logic [IDX_W-1:0]     byte_idx,
  output logic                 busy,
  output logic                 done
);

  logic ack_s;

  sync_2ff #(
    .Width(1)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d_i(ack),
    .q_o(ack_s)
  );

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] shadow_q, shadow_d;
  logic [OUTWIDTH-1:0]  byte_out_q, byte_out_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 last_lane;

  function automatic logic [OUTWIDTH-1:0] pick(input logic [DATAWIDTH-1:0] word,
                                               input logic [IDX_W-1:0]     idx);
    int unsigned lane;
    lane = lane_sel(32'(idx), LANES, LSB_FIRST);
    return OUTWIDTH'(word >> (lane * OUTWIDTH));
  endfunction

  assign last_lane = (byte_idx_q == IDX_W'(LANES - 1));

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    byte_out_d   = byte_out_q;
    byte_idx_d   = byte_idx_q;
    byte_valid_d = byte_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A stuck-high ack must not auto-accept the first beat, so drop the request.
        if (capture && !ack_s) begin
          shadow_d     = data_in;
          byte_idx_d   = '0;
          byte_out_d   = pick(data_in, '0);
          byte_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = StSend;
        end
      end
      StSend: begin
        if (ack_s) begin
          byte_valid_d = 1'b0;
          state_d      = StRelease;
        end
      end
      StRelease: begin
        if (!ack_s) begin
          if (last_lane) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            byte_idx_d   = byte_idx_q + IDX_W'(1);
            byte_out_d   = pick(shadow_q, byte_idx_q + IDX_W'(1));
            byte_valid_d = 1'b1;
            state_d      = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      byte_out_q   <= '0;
      byte_idx_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      byte_out_q   <= byte_out_d;
      byte_idx_q   <= byte_idx_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_idx   = byte_idx_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
- Reverse path of the pin-driven program loader: the loader pushes instruction bytes from the pins into the core; this block pulls a 32-bit core result back out over 8 output pins.
- On a capture request it snapshots the DATAWIDTH-bit ALU result into a shadow register. It then streams the value one byte at a time using a 4-phase valid/ack handshake with an external host.
- Sits inside the tile wrapper between the core's result bus and uo_out, with ack taken from a uio input pin.

Parameters:
- DATAWIDTH, 32, width of the captured result; must be a multiple of OUTWIDTH.
- OUTWIDTH, 8, width of one output beat.
- LSB_FIRST, 1, 1 = least-significant byte sent first; 0 = most-significant byte sent first.

Ports:
- clk  input  1  single system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- capture  input  1  one-cycle request to snapshot data_in and start a readout.
- data_in  input  DATAWIDTH  live ALU result from the core.
- ack  input  1  host acknowledge; asynchronous pin level.
- byte_out  output  OUTWIDTH  current byte of the snapshot.
- byte_valid  output  1  byte_out is stable and offered to the host.
- byte_idx  output  IDX_W  index of the byte on byte_out, 0..LANES-1, counted in transmit order.
- busy  output  1  readout in progress; capture is ignored while high.
- done  output  1  one-cycle pulse after the final byte's ack is released.

Behaviour:
- Reset values (asynchronous): state IDLE; shadow 0; byte_out 0; byte_valid 0; byte_idx 0; busy 0; done 0; both ack synchronizer flops 0.
- Derived values: LANES = DATAWIDTH/OUTWIDTH; IDX_W = clog2(LANES), minimum 1.
- ack passes through a 2-flop synchronizer to produce ack_s. All handshake decisions use ack_s only.
- FSM states:
  - IDLE: busy=0, byte_valid=0.
    - capture=1 and ack_s=0: latch data_in into shadow, set byte_idx=0, go to SEND.
    - capture=1 and ack_s=1: capture is dropped, so a stuck-high ack cannot auto-accept a byte.
  - SEND: byte_valid=1, busy=1. byte_out = lane byte_idx of shadow; with LSB_FIRST=0 the lane is LANES-1-byte_idx.
    - ack_s=1: go to RELEASE.
  - RELEASE: byte_valid=0, busy=1; byte_out holds its value.
    - ack_s=0 and byte_idx=LANES-1: go to IDLE and assert done for 1 cycle.
    - ack_s=0 otherwise: increment byte_idx and go to SEND.
- Latency:
  - capture sampled at edge N: byte_valid=1 and byte 0 valid after edge N.
  - ack pin rising before edge k: ack_s high after edge k+1; byte_valid falls after edge k+2.
  - ack falling has the same 2-cycle synchronizer delay before the next byte.
- Snapshot isolation: data_in changes after capture do not affect an in-progress readout.
- capture while busy=1 is ignored. It is neither queued nor does it restart the sequence.
- done and a new capture in the same cycle: state is IDLE on the following cycle, so the new capture is accepted normally.
- byte_idx wrap: never exceeds LANES-1; IDLE always restarts it at 0.
- rst asserted mid-readout: immediate return to reset values, the partial transfer is abandoned, and no done pulse is produced.
- Host protocol violation (ack falls before byte_valid falls): still handled correctly, because RELEASE simply waits for ack_s=0.

Decomposition:
- Shared package:
  - state enum {IDLE, SEND, RELEASE};
  - function computing LANES and IDX_W from DATAWIDTH/OUTWIDTH;
  - lane-select helper honoring LSB_FIRST.
- One sub-module: sync_2ff, a 2-flop synchronizer with asynchronous active-high rst, clearing to 0. It is reused for any other pin-level inputs in the wrapper.
- Remaining logic is a flat FSM, shadow register, index counter and output mux in result_readout.

Test Plan:
- Basic LSB-first readout: rst 3 cycles; data_in=0xDEADBEEF, pulse capture, host acks each byte with a 4-phase handshake -> byte_out sequence EF, BE, AD, DE with byte_idx 0,1,2,3; done pulses once; busy falls the same cycle done rises.
- MSB-first readout: LSB_FIRST=0, data_in=0x12345678 -> sequence 12, 34, 56, 78.
- Snapshot isolation and capture while busy: capture 0xA5A5A5A5, change data_in to 0xFFFFFFFF and pulse capture during byte 1 -> all bytes remain A5; exactly one done pulse.
- Stuck-high ack: ack held 1, pulse capture -> stays IDLE, byte_valid=0, busy=0. Then drop ack and capture 0x01020304 -> normal readout 04, 03, 02, 01.
- Reset mid-operation: assert rst while byte_idx=2 and byte_valid=1 -> all outputs 0 immediately, no done pulse. A subsequent capture of 0x0000CAFE reads out FE, CA, 00, 00.
- Latency check: ack pin rises between edges -> byte_valid falls exactly 3 edges later; capture at edge N -> byte_valid high after edge N.
